tk1_perm_sched: RTL and testbench
=================================

// Module: tk1_perm_sched
// PURPOSE
//  Sequential TK1 tweakey-schedule unit: holds one TK1 lane and advances it by RPC
//  applications of the cell permutation H per accepted step (RPC-1 when ad_i=1).
//  Replaces the fixed 4/5-permutation combinational stage with a registered,
//  handshaked, depth-parametrised stage that sits between the TK1 loader and the
//  round datapath; it tracks step and permutation counts and flags completion.
// PARAMETERS
//  CELL_W  4   bits per cell; state width W = 16*CELL_W
//  RPC     4   H applications per normal step (1..8); an AD step applies RPC-1
//  NSTEPS  10  accepted steps per schedule before done_o (1..255)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  load_i       in   1        capture tk1_i and start a new schedule
//  tk1_i        in   W        initial TK1 value
//  step_valid_i in   1        request one schedule step
//  ad_i         in   1        qualifies step: 1 = AD step (RPC-1 perms), 0 = RPC perms
//  step_ready_o out  1        step can be accepted this cycle
//  tk1_o        out  W        current registered TK1 state
//  step_cnt_o   out  8        accepted steps since load
//  perm_cnt_o   out  4        total H applications since load, mod 16
//  done_o       out  1        NSTEPS steps completed
//  rewind_i     in   1        (TK1_REWIND_EN only) restore loaded value
// BEHAVIOUR
//  - H: out cell i = in cell P[i], P = {9,15,8,13,10,14,12,11,0,1,2,3,4,5,6,7};
//    cell i = bits [CELL_W*i +: CELL_W]. H has order 16.
//  - Reset: FSM=IDLE, tk1_o=0, step_cnt_o=0, perm_cnt_o=0, done_o=0, step_ready_o=0.
//  - FSM IDLE -> RUN on load_i; RUN -> DONE when accepting step with step_cnt_o==NSTEPS-1;
//    DONE -> RUN only on load_i (or rewind). step_ready_o=1 only in RUN; done_o=1 only in DONE.
//  - Step accepted iff step_valid_i & step_ready_o & !load_i; one-cycle latency:
//    tk1_o = H^k(tk1_o) in next cycle, k = ad_i ? RPC-1 : RPC; step_cnt_o+1;
//    perm_cnt_o += k (4-bit wrap). RPC=1 with ad_i=1: k=0, state held, counters still step.
//  - load_i: any state, takes priority over step/rewind: tk1_o<=tk1_i, counters=0, RUN.
//  - step_valid_i while not ready: ignored, no state change; requester must hold it.
//  - step_cnt_o never wraps: saturates at NSTEPS via DONE.
//  - Permutation network combinational, depth RPC; tk1_o driven straight from register.
//  - rst asserted mid-schedule: all state cleared immediately, pending step lost.
// CONFIGURATION
//  TK1_REWIND_EN defined: extra W-bit register saves tk1_i at load; rewind_i (RUN or DONE,
//   not IDLE) restores tk1_o to it, counters=0, state RUN, next cycle; priority
//   load_i > rewind_i > step. Rewind in IDLE ignored.
//  TK1_REWIND_EN undefined: no rewind_i port, no save register; re-load required.
// TESTING
//  1 RPC=1: load 0xFEDCBA9876543210, step ad=0 -> tk1_o=0x76543210BCEAD8F9, perm_cnt_o=1.
//  2 RPC=4: load X, 4 steps ad=0 -> tk1_o==X, perm_cnt_o=0, step_cnt_o=4.
//  3 RPC=4: load X, step ad=1 -> tk1_o==H^3(X), perm_cnt_o=3; then ad=0 -> perm_cnt_o=7.
//  4 NSTEPS=10: 10 back-to-back steps -> done_o=1, step_ready_o=0; 11th valid ignored;
//    load_i with step_valid_i same cycle -> tk1_o=tk1_i, counters 0, no step applied.
//  5 rst pulse mid-run (step_cnt_o=5) -> all outputs 0 asynchronously, IDLE, steps ignored.
//  6 TK1_REWIND_EN: load X, 3 steps, rewind_i with step_valid_i -> tk1_o==X, step_cnt_o=0.

Source files
------------

// File: rtl/tk1_perm_sched_if.sv
// TK1 schedule bus: loader/step request inputs and registered schedule state outputs.
// No storage; pure signal bundle shared by the requester (master) and the schedule unit (slave).
// Optional TK1_REWIND_EN adds rewind_i; with it undefined the port does not exist.
interface tk1_perm_sched_if #(
    parameter int W = 64
);
    logic         load_i;
    logic [W-1:0] tk1_i;
    logic         step_valid_i;
    logic         ad_i;
    logic         step_ready_o;
    logic [W-1:0] tk1_o;
    logic [7:0]   step_cnt_o;
    logic [3:0]   perm_cnt_o;
    logic         done_o;
`ifdef TK1_REWIND_EN
    logic         rewind_i;
`endif

    modport master (
`ifdef TK1_REWIND_EN
        output rewind_i,
`endif
        output load_i, tk1_i, step_valid_i, ad_i,
        input  step_ready_o, tk1_o, step_cnt_o, perm_cnt_o, done_o
    );

    modport slave (
`ifdef TK1_REWIND_EN
        input  rewind_i,
`endif
        input  load_i, tk1_i, step_valid_i, ad_i,
        output step_ready_o, tk1_o, step_cnt_o, perm_cnt_o, done_o
    );
endinterface

// File: rtl/tk1_perm_sched.sv
// TK1 tweakey schedule: registered lane advanced by RPC (RPC-1 for AD) cell permutations per step.
// Latency: one cycle from accepted step/load/rewind to updated tk1_o and counters.
// Backpressure: step_ready_o high only while running; unaccepted requests must be held. Option: TK1_REWIND_EN.
module tk1_perm_sched #(
    parameter int CELL_W = 4,
    parameter int RPC    = 4,
    parameter int NSTEPS = 10
) (
    input  logic             clk,
    input  logic             rst,
    tk1_perm_sched_if.slave  bus
);
    localparam int          W      = 16 * CELL_W;
    // Nibble i holds the source cell index for output cell i.
    localparam logic [63:0] PERM   = 64'h7654_3210_BCEA_D8F9;
    localparam logic [3:0]  K_STEP = 4'(RPC);
    localparam logic [3:0]  K_AD   = 4'(RPC - 1);
    localparam logic [7:0]  LAST   = 8'(NSTEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   tk1_q, tk1_d;
    logic [7:0]     step_q, step_d;
    logic [3:0]     perm_q, perm_d;
    logic [W-1:0]   chain [0:RPC];
    logic           step_go;

    function automatic logic [W-1:0] h_perm(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[CELL_W*i +: CELL_W] = x[CELL_W*int'(PERM[4*i +: 4]) +: CELL_W];
        end
        return r;
    endfunction

    // Unrolled permutation network: chain[j] = H^j(current state).
    assign chain[0] = tk1_q;
    for (genvar j = 0; j < RPC; j++) begin : g_h
        assign chain[j+1] = h_perm(chain[j]);
    end

    assign step_go = bus.step_valid_i && (state_q == RUN) && !bus.load_i;

`ifdef TK1_REWIND_EN
    logic [W-1:0] save_q;
    logic         rewind_go;

    assign rewind_go = bus.rewind_i && (state_q != IDLE) && !bus.load_i;

    // Snapshot of the loaded key so a schedule can be replayed without the loader.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             save_q <= '0;
        else if (bus.load_i) save_q <= bus.tk1_i;
    end
`endif

    // Next-state and datapath selection: load beats rewind beats step.
    always_comb begin
        state_d = state_q;
        tk1_d   = tk1_q;
        step_d  = step_q;
        perm_d  = perm_q;
        if (bus.load_i) begin
            state_d = RUN;
            tk1_d   = bus.tk1_i;
            step_d  = '0;
            perm_d  = '0;
        end
`ifdef TK1_REWIND_EN
        else if (rewind_go) begin
            state_d = RUN;
            tk1_d   = save_q;
            step_d  = '0;
            perm_d  = '0;
        end
`endif
        else if (step_go) begin
            tk1_d  = bus.ad_i ? chain[RPC-1] : chain[RPC];
            step_d = step_q + 8'd1;
            perm_d = perm_q + (bus.ad_i ? K_AD : K_STEP);
            if (step_q == LAST) state_d = DONE;
        end
    end

    // State and datapath registers; reset clears the whole schedule immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tk1_q   <= '0;
            step_q  <= '0;
            perm_q  <= '0;
        end else begin
            state_q <= state_d;
            tk1_q   <= tk1_d;
            step_q  <= step_d;
            perm_q  <= perm_d;
        end
    end

    assign bus.tk1_o        = tk1_q;
    assign bus.step_cnt_o   = step_q;
    assign bus.perm_cnt_o   = perm_q;
    assign bus.step_ready_o = (state_q == RUN);
    assign bus.done_o       = (state_q == DONE);
endmodule

// File: tb/tb_tk1_perm_sched.sv
// Bench for tk1_perm_sched: an RPC=1 instance for the single-permutation vector and an
// RPC=4/NSTEPS=10 instance driven cycle by cycle against a scoreboard of expected states.
// Rewind cases are exercised only when TK1_REWIND_EN is defined.
module tb_tk1_perm_sched;
`ifdef TK1_REWIND_EN
    localparam bit REW_EN = 1'b1;
`else
    localparam bit REW_EN = 1'b0;
`endif
    localparam int NST = 10;
    localparam int P_TBL [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tk1_perm_sched_if #(.W(64)) ia ();
    tk1_perm_sched_if #(.W(64)) ib ();

    tk1_perm_sched #(.CELL_W(4), .RPC(1), .NSTEPS(NST)) ua (.clk(clk), .rst(rst), .bus(ia.slave));
    tk1_perm_sched #(.CELL_W(4), .RPC(4), .NSTEPS(NST)) ub (.clk(clk), .rst(rst), .bus(ib.slave));

    typedef struct {
        string       tag;
        logic [63:0] tk;
        logic [7:0]  sc;
        logic [3:0]  pc;
        logic        dn;
        logic        rd;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;

    // Reference model of instance ub (0 idle, 1 run, 2 done)
    int          m_st = 0;
    logic [63:0] m_tk = '0;
    logic [63:0] m_save = '0;
    logic [7:0]  m_sc = '0;
    logic [3:0]  m_pc = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] h1(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = x[4*P_TBL[i] +: 4];
        return r;
    endfunction

    function automatic logic [63:0] hpow(input logic [63:0] x, input int k);
        logic [63:0] r;
        r = x;
        for (int i = 0; i < k; i++) r = h1(r);
        return r;
    endfunction

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".tk1"},   ib.tk1_o,             e.tk);
            chk({e.tag, ".step"},  64'(ib.step_cnt_o),   64'(e.sc));
            chk({e.tag, ".perm"},  64'(ib.perm_cnt_o),   64'(e.pc));
            chk({e.tag, ".done"},  64'(ib.done_o),       64'(e.dn));
            chk({e.tag, ".ready"}, 64'(ib.step_ready_o), 64'(e.rd));
        end
    endtask

    // One cycle on ub: compare the previous cycle's outcome, drive, predict, push.
    task automatic cyc(input string tag, input logic ld, input logic [63:0] tk,
                       input logic vld, input logic ad, input logic rw);
        exp_t e;
        int   k;
        @(negedge clk);
        pop_cmp();
        ib.load_i       = ld;
        ib.tk1_i        = tk;
        ib.step_valid_i = vld;
        ib.ad_i         = ad;
`ifdef TK1_REWIND_EN
        ib.rewind_i     = rw;
`endif
        if (ld) begin
            m_tk = tk; m_save = tk; m_sc = 0; m_pc = 0; m_st = 1;
        end else if (REW_EN && rw && m_st != 0) begin
            m_tk = m_save; m_sc = 0; m_pc = 0; m_st = 1;
        end else if (vld && m_st == 1) begin
            k = ad ? 3 : 4;
            m_tk = hpow(m_tk, k);
            if (m_sc == 8'(NST - 1)) m_st = 2;
            m_sc = m_sc + 8'd1;
            m_pc = m_pc + 4'(k);
        end
        e.tag = tag; e.tk = m_tk; e.sc = m_sc; e.pc = m_pc;
        e.dn = (m_st == 2); e.rd = (m_st == 1);
        sb.push_back(e);
    endtask

    task automatic settle();
        @(negedge clk);
        pop_cmp();
        ib.load_i = 0; ib.step_valid_i = 0; ib.ad_i = 0;
`ifdef TK1_REWIND_EN
        ib.rewind_i = 0;
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".a_tk1"}, ia.tk1_o, 64'h0);
        chk({tag, ".tk1"},   ib.tk1_o, 64'h0);
        chk({tag, ".step"},  64'(ib.step_cnt_o), 64'h0);
        chk({tag, ".perm"},  64'(ib.perm_cnt_o), 64'h0);
        chk({tag, ".done"},  64'(ib.done_o), 64'h0);
        chk({tag, ".ready"}, 64'(ib.step_ready_o), 64'h0);
    endtask

    initial begin
        logic [63:0] x;
        x = 64'hFEDC_BA98_7654_3210;
        ia.load_i = 0; ia.tk1_i = '0; ia.step_valid_i = 0; ia.ad_i = 0;
        ib.load_i = 0; ib.tk1_i = '0; ib.step_valid_i = 0; ib.ad_i = 0;
`ifdef TK1_REWIND_EN
        ia.rewind_i = 0; ib.rewind_i = 0;
`endif
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // RPC=1 instance: one H per normal step, none for an AD step
        @(negedge clk);
        ia.load_i = 1; ia.tk1_i = x;
        @(negedge clk);
        chk("a_load.tk1", ia.tk1_o, x);
        chk("a_load.ready", 64'(ia.step_ready_o), 64'h1);
        ia.load_i = 0; ia.step_valid_i = 1; ia.ad_i = 0;
        @(negedge clk);
        chk("a_step.tk1", ia.tk1_o, 64'h7654_3210_BCEA_D8F9);
        chk("a_step.perm", 64'(ia.perm_cnt_o), 64'h1);
        ia.ad_i = 1;
        @(negedge clk);
        ia.step_valid_i = 0; ia.ad_i = 0;
        chk("a_ad.tk1", ia.tk1_o, 64'h7654_3210_BCEA_D8F9);
        chk("a_ad.step", 64'(ia.step_cnt_o), 64'h2);
        chk("a_ad.perm", 64'(ia.perm_cnt_o), 64'h1);

        // RPC=4 instance: steps in IDLE are ignored
        cyc("idle_vld", 0, 64'h0, 1, 0, 0);
        // H has order 16: four full steps return the loaded value
        cyc("t2_load", 1, x, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("t2_step", 0, 64'h0, 1, 0, 0);
        settle();
        chk("t2_identity", ib.tk1_o, x);
        chk("t2_perm", 64'(ib.perm_cnt_o), 64'h0);
        // AD step then normal step
        cyc("t3_load", 1, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        cyc("t3_ad", 0, 64'h0, 1, 1, 0);
        cyc("t3_norm", 0, 64'h0, 1, 0, 0);
        settle();
        chk("t3_perm", 64'(ib.perm_cnt_o), 64'h7);
        // Full schedule back-to-back, extra request ignored, then load beats step
        cyc("t4_load", 1, {$urandom, $urandom}, 0, 0, 0);
        for (int i = 0; i < NST; i++) cyc("t4_step", 0, 64'h0, 1, 1'($urandom_range(0, 1)), 0);
        cyc("t4_extra", 0, 64'h0, 1, 0, 0);
        cyc("t4_extra2", 0, 64'h0, 1, 1, 0);
        cyc("t4_reload", 1, 64'hA5A5_5A5A_0F0F_F0F0, 1, 0, 0);
        cyc("t4_after", 0, 64'h0, 1, 0, 0);
        // Asynchronous reset mid-schedule
        cyc("t5_load", 1, x, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("t5_step", 0, 64'h0, 1, 0, 0);
        settle();
        chk("t5_pre_step", 64'(ib.step_cnt_o), 64'h5);
        ib.step_valid_i = 1;
        #2 rst = 1'b1;
        #1 chk_zero("t5_rst");
        m_st = 0; m_tk = '0; m_sc = '0; m_pc = '0; m_save = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc("t5_ignored", 0, 64'h0, 1, 0, 0);
        cyc("t5_ignored2", 0, 64'h0, 1, 1, 0);
`ifdef TK1_REWIND_EN
        cyc("t6_idle_rw", 0, 64'h0, 0, 0, 1);
        cyc("t6_load", 1, x, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t6_step", 0, 64'h0, 1, 0, 0);
        cyc("t6_rewind", 0, 64'h0, 1, 0, 1);
        settle();
        chk("t6_tk1", ib.tk1_o, x);
        chk("t6_step", 64'(ib.step_cnt_o), 64'h0);
        cyc("t6_load_rw", 1, 64'h1111_2222_3333_4444, 0, 0, 1);
        cyc("t6_after", 0, 64'h0, 1, 1, 0);
`endif
        cyc("end", 0, 64'h0, 0, 0, 0);
        settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
